// File: rtl/mac_vec.sv
// Pipelined signed vector multiply-accumulate with a valid/ready beat input and a held result.
// Define MAC_VEC_SAT_EN for a saturating accumulator with a sticky overflow flag.
module mac_vec #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_act,
  input  logic [LANES*DATA_WIDTH-1:0]   in_weight,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic [CNT_WIDTH-1:0]          out_beats,
  output logic                          out_ovf
);

  localparam int unsigned SumWidth = 2 * DATA_WIDTH + $clog2(LANES);
  localparam int unsigned OpWidth  = LANES * DATA_WIDTH;

  typedef enum logic [1:0] {StAccum, StFlush, StOut} state_e;

  state_e               st_q, st_d;
  logic [1:0]           flush_cnt_q, flush_cnt_d;
  logic [OpWidth-1:0]   act_q, act_d;
  logic [OpWidth-1:0]   wgt_q, wgt_d;
  logic                 s1_vld_q, s1_vld_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [SumWidth-1:0]  sum_q, sum_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic                        accept;
  logic                        hshake;
  logic [SumWidth-1:0]         a_ext, w_ext;
  logic signed [SumWidth-1:0]  sum_s;
  logic signed [ACC_WIDTH-1:0] sum_ext;
  logic [ACC_WIDTH-1:0]        acc_next;
  logic                        clamp;

  assign in_ready = (st_q == StAccum);
  assign accept   = in_valid && in_ready;
  assign hshake   = (st_q == StOut) && out_ready;

  // Operands are widened to the full sum width so every product and partial sum is exact.
  always_comb begin
    a_ext = '0;
    w_ext = '0;
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      a_ext = {{(SumWidth-DATA_WIDTH){act_q[i*DATA_WIDTH+DATA_WIDTH-1]}},
               act_q[i*DATA_WIDTH +: DATA_WIDTH]};
      w_ext = {{(SumWidth-DATA_WIDTH){wgt_q[i*DATA_WIDTH+DATA_WIDTH-1]}},
               wgt_q[i*DATA_WIDTH +: DATA_WIDTH]};
      sum_d = sum_d + a_ext * w_ext;
    end
  end

  assign sum_s   = sum_q;
  assign sum_ext = ACC_WIDTH'(sum_s);

`ifdef MAC_VEC_SAT_EN
  logic [ACC_WIDTH:0] acc_sum;

  always_comb begin
    acc_sum  = {acc_q[ACC_WIDTH-1], acc_q} + {sum_ext[ACC_WIDTH-1], sum_ext};
    acc_next = acc_sum[ACC_WIDTH-1:0];
    clamp    = 1'b0;
    // Top two bits disagreeing means the exact sum left the representable range.
    if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1]) begin
      clamp    = 1'b1;
      acc_next = acc_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  assign acc_next = acc_q + sum_ext;
  assign clamp    = 1'b0;
`endif

  always_comb begin
    st_d        = st_q;
    flush_cnt_d = flush_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (st_q)
      StAccum: begin
        if (accept && in_last) begin
          st_d        = StFlush;
          flush_cnt_d = '0;
        end
      end
      StFlush: begin
        // Wait until the last beat has drained through stages 2 and 3 into acc_q.
        if (flush_cnt_q == 2'd2) begin
          st_d        = StOut;
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      StOut: begin
        if (out_ready) begin
          st_d        = StAccum;
          out_valid_d = 1'b0;
        end
      end
      default: st_d = StAccum;
    endcase
  end

  always_comb begin
    act_d    = accept ? in_act : act_q;
    wgt_d    = accept ? in_weight : wgt_q;
    s1_vld_d = accept;
    s2_vld_d = s1_vld_q;

    acc_d = acc_q;
    if (hshake) begin
      acc_d = '0;
    end else if (s2_vld_q) begin
      acc_d = acc_next;
    end

    cnt_d = cnt_q;
    if (hshake) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    ovf_d = ovf_q;
    if (hshake) begin
      ovf_d = 1'b0;
    end else if (s2_vld_q && clamp) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q        <= StAccum;
      flush_cnt_q <= '0;
      act_q       <= '0;
      wgt_q       <= '0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      flush_cnt_q <= flush_cnt_d;
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_vec.sv
// Directed bench for mac_vec: default instance plus ACC_WIDTH=12 and CNT_WIDTH=2 instances
// sharing one stimulus stream to cover accumulator overflow and beat-count saturation.
module tb_mac_vec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_act;
  logic [15:0] in_weight;
  logic        in_last;
  logic        out_ready;

  logic        rdy16, vld16, ovf16;
  logic [15:0] data16;
  logic [7:0]  beats16;
  logic        rdy12, vld12, ovf12;
  logic [11:0] data12;
  logic [7:0]  beats12;
  logic        rdyc2, vldc2, ovfc2;
  logic [15:0] datac2;
  logic [1:0]  beatsc2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_vec u16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16), .in_act(in_act),
    .in_weight(in_weight), .in_last(in_last), .out_valid(vld16), .out_ready(out_ready),
    .out_data(data16), .out_beats(beats16), .out_ovf(ovf16)
  );

  mac_vec #(.ACC_WIDTH(12)) u12 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy12), .in_act(in_act),
    .in_weight(in_weight), .in_last(in_last), .out_valid(vld12), .out_ready(out_ready),
    .out_data(data12), .out_beats(beats12), .out_ovf(ovf12)
  );

  mac_vec #(.CNT_WIDTH(2)) uc2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyc2), .in_act(in_act),
    .in_weight(in_weight), .in_last(in_last), .out_valid(vldc2), .out_ready(out_ready),
    .out_data(datac2), .out_beats(beatsc2), .out_ovf(ovfc2)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int l0, input int l1, input int l2, input int l3);
    logic [15:0] r;
    r[3:0]   = l0[3:0];
    r[7:4]   = l1[3:0];
    r[11:8]  = l2[3:0];
    r[15:12] = l3[3:0];
    return r;
  endfunction

  task automatic beat(input logic [15:0] a, input logic [15:0] w, input logic l);
    in_valid  = 1'b1;
    in_act    = a;
    in_weight = w;
    in_last   = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Call right after the last beat's accepting edge; counts edges until out_valid.
  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (vld16 !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 3);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, vld16, 0);
    chk({tag, "_hs_ready"}, rdy16, 1);
    chk({tag, "_hs_beats"}, beats16, 0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_act    = '0;
    in_weight = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", vld16, 0);
    chk("rst_data", data16, 0);
    chk("rst_beats", beats16, 0);
    chk("rst_ovf", ovf16, 0);
    reset = 1'b1;
    chk("rst_ready", rdy16, 1);

    // Single beat 1+2+3+4
    beat(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 1'b1);
    chk("s1_ready_low", rdy16, 0);
    wait_out("s1");
    chk("s1_data", $signed(data16), 10);
    chk("s1_beats", beats16, 1);
    chk("s1_data12", $signed(data12), 10);
    handshake("s1");

    // Four beats of 4*(-8*-8)
    for (int i = 0; i < 4; i++) beat(pk(-8, -8, -8, -8), pk(-8, -8, -8, -8), i == 3);
    chk("s2_ready_low", rdy16, 0);
    wait_out("s2");
    chk("s2_data", $signed(data16), 1024);
    chk("s2_beats", beats16, 4);
    chk("s2_beats_sat", beatsc2, 3);
    chk("s2_data12", $signed(data12), 1024);
    // Consumer stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("s3_hold_valid", vld16, 1);
      chk("s3_hold_data", $signed(data16), 1024);
      chk("s3_hold_ready", rdy16, 0);
    end
    handshake("s3");

    // Eight beats of 256: exceeds a 12-bit accumulator
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) beat(pk(-8, -8, -8, -8), pk(-8, -8, -8, -8), i == 7);
    out_ready = 1'b1;
    wait_out("s4");
    chk("s4_data16", $signed(data16), 2048);
    chk("s4_beats16", beats16, 8);
    chk("s4_ovf16", ovf16, 0);
    chk("s4_beats_sat", beatsc2, 3);
`ifdef MAC_VEC_SAT_EN
    chk("s4_data12", $signed(data12), 2047);
    chk("s4_ovf12", ovf12, 1);
`else
    chk("s4_data12", $signed(data12), -2048);
    chk("s4_ovf12", ovf12, 0);
`endif
    // out_ready was already high on OUT entry: one-cycle OUT
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("s4_one_cycle_out", vld16, 0);
    chk("s4_ovf_cleared", ovf12, 0);
    chk("s4_ready_back", rdy16, 1);

    // Reset with two beats in flight
    beat(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 1'b0);
    beat(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("s5_rst_beats", beats16, 0);
    chk("s5_rst_ready", rdy16, 1);
    beat(pk(1, 0, 0, 0), pk(3, 0, 0, 0), 1'b1);
    wait_out("s5");
    chk("s5_data", $signed(data16), 3);
    chk("s5_beats", beats16, 1);
    handshake("s5");

    // in_valid toggling every cycle
    for (int i = 0; i < 3; i++) begin
      beat(pk(5, 0, 0, 0), pk(1, 0, 0, 0), i == 2);
      if (i < 2) begin
        @(posedge clk);
        #1;
        chk("s6_idle_ready", rdy16, 1);
      end
    end
    wait_out("s6");
    chk("s6_data", $signed(data16), 15);
    chk("s6_beats", beats16, 3);
    handshake("s6");

    // Mixed signs: -56 + 64 + 6 - 5
    beat(pk(7, -8, 3, -1), pk(-8, -8, 2, 5), 1'b1);
    wait_out("s7");
    chk("s7_data", $signed(data16), 9);
    chk("s7_data12", $signed(data12), 9);
    handshake("s7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
